// File: rtl/perf_fpga_mc_axi_ctrl_parser_pkg.sv
// perf_fpga_mc_axi_ctrl_parser_pkg
//   Shared types and constants for the multi-channel bench control block.
//   Provides:
//   - the request descriptor struct;
//   - the AXI4-Lite widths;
//   - the register word indices;
//   - the byte-enable and field-truncation helpers.
package perf_fpga_mc_axi_ctrl_parser_pkg;

   localparam int AXIL_DATA_BITS = 64;
   localparam int AXIL_STRB_BITS = AXIL_DATA_BITS / 8;
   localparam int AXIL_ADDR_BITS = 16;

   localparam int LEN_BITS   = 32;
   localparam int VADDR_BITS = 48;
   localparam int PID_BITS   = 6;

   localparam int BANK_REGS = 8;
   localparam int BANK_BASE = 8;

   // Global register word indices
   localparam int REG_RESET  = 0;
   localparam int REG_N_REPS = 1;
   localparam int REG_STATUS = 2;
   localparam int REG_TIMER  = 3;

   // Offsets inside a channel bank
   localparam logic [2:0] OFF_DOORBELL = 3'd0;
   localparam logic [2:0] OFF_N_BEATS  = 3'd1;
   localparam logic [2:0] OFF_LEN_A    = 3'd2;
   localparam logic [2:0] OFF_LEN_B    = 3'd3;
   localparam logic [2:0] OFF_VADDR_A  = 3'd4;
   localparam logic [2:0] OFF_VADDR_B  = 3'd5;
   localparam logic [2:0] OFF_PID      = 3'd6;
   localparam logic [2:0] OFF_DONE     = 3'd7;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef struct packed {
      logic [1:0]            ctrl;
      logic [63:0]           n_beats;
      logic [LEN_BITS-1:0]   len_A;
      logic [LEN_BITS-1:0]   len_B;
      logic [VADDR_BITS-1:0] vaddr_A;
      logic [VADDR_BITS-1:0] vaddr_B;
      logic [PID_BITS-1:0]   pid;
   } bench_req_t;

   typedef enum logic [1:0] {WR_IDLE, WR_ACK, WR_RESP} wr_state_e;
   typedef enum logic [1:0] {RD_IDLE, RD_ACK, RD_RESP} rd_state_e;

   // Merge write data into an existing 64-bit word under byte enables.
   function automatic logic [63:0] apply_wstrb(input logic [63:0] old_val,
                                               input logic [63:0] wdata,
                                               input logic [7:0]  wstrb);
      logic [63:0] res;
      res = old_val;
      for (int b = 0; b < 8; b++) begin
         if (wstrb[b]) res[8*b +: 8] = wdata[8*b +: 8];
      end
      return res;
   endfunction

   // Storage mask for each bank field; bits above the field width read as 0.
   function automatic logic [63:0] field_mask(input logic [2:0] off);
      logic [63:0] m;
      m = '1;
      unique case (off)
         OFF_LEN_A, OFF_LEN_B:     m = {{(64-LEN_BITS){1'b0}},   {LEN_BITS{1'b1}}};
         OFF_VADDR_A, OFF_VADDR_B: m = {{(64-VADDR_BITS){1'b0}}, {VADDR_BITS{1'b1}}};
         OFF_PID:                  m = {{(64-PID_BITS){1'b0}},   {PID_BITS{1'b1}}};
         default:                  m = '1;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/perf_fpga_mc_axi_ctrl_parser_req_queue.sv
// perf_fpga_mc_axi_ctrl_parser_req_queue
//   Synchronous descriptor FIFO for one request channel.
//   Ports:
//   - aclk/aresetn: clock and synchronous active-low reset.
//   - flush: empties the queue in this cycle.
//   - push/din: enqueue; ignored while full.
//   - pop: dequeue; ignored while empty.
//   - dout: head entry; zero when the queue is empty.
//   - full/empty/count: occupancy, all taken from the registered count.
module perf_fpga_mc_axi_ctrl_parser_req_queue
   import perf_fpga_mc_axi_ctrl_parser_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   aclk,
   input  logic                   aresetn,
   input  logic                   flush,
   input  logic                   push,
   input  bench_req_t             din,
   input  logic                   pop,
   output bench_req_t             dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PW = $clog2(DEPTH);

   bench_req_t    mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW:0]   count_q, count_d;
   logic          push_en, pop_en;

   always_comb begin
      full     = (count_q == (PW+1)'(DEPTH));
      empty    = (count_q == '0);
      push_en  = push && !full;
      pop_en   = pop && !empty;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_en) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop_en)  rd_ptr_d = rd_ptr_q + PW'(1);
         count_d = count_q + (PW+1)'(push_en) - (PW+1)'(pop_en);
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset; the head is masked while empty instead.
   always_ff @(posedge aclk) begin
      if (push_en && !flush) mem_q[wr_ptr_q] <= din;
   end

   assign dout  = empty ? '0 : mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/perf_fpga_mc_axi_ctrl_parser.sv
// perf_fpga_mc_axi_ctrl_parser
//   AXI4-Lite CSR block for the multi-channel benchmark. It holds:
//   - the global registers RESET, N_REPS, STATUS and TIMER;
//   - one request register bank per channel.
//   A doorbell write pushes a descriptor into that channel's queue.
//   Ports:
//   - aclk/aresetn: clock and synchronous active-low reset.
//   - axi_ctrl_*: 64-bit AXI4-Lite slave (byte addresses, 8 bytes per word).
//   - bench_reset: one-cycle pulse; it also flushes every queue.
//   - bench_n_reps: the N_REPS register.
//   - bench_done: per-channel completion counts, read back through the banks.
//   - bench_timer: read back at word 3.
//   - req_valid/req_ready/req_desc: per-channel descriptor stream.
module perf_fpga_mc_axi_ctrl_parser
   import perf_fpga_mc_axi_ctrl_parser_pkg::*;
#(
   parameter int N_CH   = 2,
   parameter int QDEPTH = 4
) (
   input  logic                        aclk,
   input  logic                        aresetn,
   input  logic [AXIL_ADDR_BITS-1:0]   axi_ctrl_awaddr,
   input  logic                        axi_ctrl_awvalid,
   output logic                        axi_ctrl_awready,
   input  logic [AXIL_DATA_BITS-1:0]   axi_ctrl_wdata,
   input  logic [AXIL_STRB_BITS-1:0]   axi_ctrl_wstrb,
   input  logic                        axi_ctrl_wvalid,
   output logic                        axi_ctrl_wready,
   output logic [1:0]                  axi_ctrl_bresp,
   output logic                        axi_ctrl_bvalid,
   input  logic                        axi_ctrl_bready,
   input  logic [AXIL_ADDR_BITS-1:0]   axi_ctrl_araddr,
   input  logic                        axi_ctrl_arvalid,
   output logic                        axi_ctrl_arready,
   output logic [AXIL_DATA_BITS-1:0]   axi_ctrl_rdata,
   output logic [1:0]                  axi_ctrl_rresp,
   output logic                        axi_ctrl_rvalid,
   input  logic                        axi_ctrl_rready,
   output logic                        bench_reset,
   output logic [31:0]                 bench_n_reps,
   input  logic [N_CH-1:0][31:0]       bench_done,
   input  logic [63:0]                 bench_timer,
   output logic [N_CH-1:0]             req_valid,
   input  logic [N_CH-1:0]             req_ready,
   output bench_req_t [N_CH-1:0]       req_desc
);

   localparam int IDX_W = AXIL_ADDR_BITS - 3;
   localparam int CW    = $clog2(QDEPTH) + 1;
   localparam int N_WORDS = BANK_BASE + BANK_REGS * N_CH;

   wr_state_e   wr_state_q, wr_state_d;
   rd_state_e   rd_state_q, rd_state_d;
   logic [1:0]  bresp_q, bresp_d;
   logic [1:0]  rresp_q, rresp_d;
   logic [63:0] rdata_q, rdata_d;
   logic        bench_reset_q, bench_reset_d;
   logic [31:0] n_reps_q, n_reps_d;
   logic [N_CH-1:0] ovf_q, ovf_d;
   // Bank offsets 1..6 are stored; index is offset-1.
   logic [63:0] bank_q [N_CH][6];
   logic [63:0] bank_d [N_CH][6];

   logic [N_CH-1:0]          q_push, q_pop, q_full, q_empty;
   bench_req_t [N_CH-1:0]    q_din;
   logic [N_CH-1:0][CW-1:0]  q_count;

   logic [IDX_W-1:0] wr_idx, rd_idx;
   logic [2:0]       wr_off, rd_off;
   logic             wr_in_banks, rd_in_banks;
   logic [63:0]      status_vec;

   assign wr_idx      = axi_ctrl_awaddr[AXIL_ADDR_BITS-1:3];
   assign rd_idx      = axi_ctrl_araddr[AXIL_ADDR_BITS-1:3];
   assign wr_off      = wr_idx[2:0];
   assign rd_off      = rd_idx[2:0];
   assign wr_in_banks = (wr_idx >= IDX_W'(BANK_BASE)) && (wr_idx < IDX_W'(N_WORDS));
   assign rd_in_banks = (rd_idx >= IDX_W'(BANK_BASE)) && (rd_idx < IDX_W'(N_WORDS));

   assign req_valid = ~q_empty;
   assign q_pop     = req_valid & req_ready;

   always_comb begin
      status_vec = '0;
      for (int ch = 0; ch < N_CH; ch++) begin
         status_vec[ch]      = q_full[ch];
         status_vec[8 + ch]  = q_empty[ch];
         status_vec[16 + ch] = ovf_q[ch];
         status_vec[24 + ch] = req_valid[ch];
      end
   end

   // Write path: AW and W are taken together.
   // Ready goes high the cycle after both valids.
   always_comb begin
      wr_state_d    = wr_state_q;
      bresp_d       = bresp_q;
      bench_reset_d = 1'b0;
      n_reps_d      = n_reps_q;
      ovf_d         = ovf_q;
      bank_d        = bank_q;
      q_push        = '0;
      for (int ch = 0; ch < N_CH; ch++) begin
         q_din[ch].ctrl    = axi_ctrl_wdata[1:0];
         q_din[ch].n_beats = bank_q[ch][0];
         q_din[ch].len_A   = bank_q[ch][1][LEN_BITS-1:0];
         q_din[ch].len_B   = bank_q[ch][2][LEN_BITS-1:0];
         q_din[ch].vaddr_A = bank_q[ch][3][VADDR_BITS-1:0];
         q_din[ch].vaddr_B = bank_q[ch][4][VADDR_BITS-1:0];
         q_din[ch].pid     = bank_q[ch][5][PID_BITS-1:0];
      end
      unique case (wr_state_q)
         WR_IDLE: begin
            if (axi_ctrl_awvalid && axi_ctrl_wvalid) wr_state_d = WR_ACK;
         end
         WR_ACK: begin
            if (axi_ctrl_awvalid && axi_ctrl_wvalid) begin
               wr_state_d = WR_RESP;
               bresp_d    = RESP_OKAY;
               if (wr_idx == IDX_W'(REG_RESET)) begin
                  bench_reset_d = axi_ctrl_wstrb[0] & axi_ctrl_wdata[0];
               end else if (wr_idx == IDX_W'(REG_N_REPS)) begin
                  for (int b = 0; b < 4; b++) begin
                     if (axi_ctrl_wstrb[b]) n_reps_d[8*b +: 8] = axi_ctrl_wdata[8*b +: 8];
                  end
               end else if (wr_idx == IDX_W'(REG_STATUS)) begin
                  // Only the overflow bits are writable, as write-1-to-clear.
                  ovf_d = ovf_q & ~(axi_ctrl_wdata[16 +: N_CH] & {N_CH{axi_ctrl_wstrb[2]}});
               end else if (!wr_in_banks) begin
                  bresp_d = RESP_SLVERR;
               end else begin
                  for (int ch = 0; ch < N_CH; ch++) begin
                     if (wr_idx[IDX_W-1:3] == (IDX_W-3)'(ch + 1)) begin
                        if (wr_off == OFF_DOORBELL) begin
                           if (axi_ctrl_wstrb[0]) begin
                              // Full is judged on the registered count.
                              // A same-cycle pop does not make room.
                              if (q_full[ch]) begin
                                 ovf_d[ch] = 1'b1;
                                 bresp_d   = RESP_SLVERR;
                              end else begin
                                 q_push[ch] = 1'b1;
                              end
                           end
                        end else if (wr_off == OFF_DONE) begin
                           bresp_d = RESP_SLVERR;
                        end else begin
                           bank_d[ch][wr_off - 3'd1] =
                              apply_wstrb(bank_q[ch][wr_off - 3'd1], axi_ctrl_wdata, axi_ctrl_wstrb)
                              & field_mask(wr_off);
                        end
                     end
                  end
               end
            end
         end
         WR_RESP: begin
            if (axi_ctrl_bready) wr_state_d = WR_IDLE;
         end
         default: wr_state_d = WR_IDLE;
      endcase
   end

   // Read path: the address is taken one cycle after arvalid.
   // Data is registered on acceptance.
   always_comb begin
      rd_state_d = rd_state_q;
      rdata_d    = rdata_q;
      rresp_d    = rresp_q;
      unique case (rd_state_q)
         RD_IDLE: begin
            if (axi_ctrl_arvalid) rd_state_d = RD_ACK;
         end
         RD_ACK: begin
            if (axi_ctrl_arvalid) begin
               rd_state_d = RD_RESP;
               rresp_d    = RESP_OKAY;
               rdata_d    = '0;
               if (rd_idx == IDX_W'(REG_RESET)) begin
                  rdata_d = '0;
               end else if (rd_idx == IDX_W'(REG_N_REPS)) begin
                  rdata_d = {32'h0, n_reps_q};
               end else if (rd_idx == IDX_W'(REG_STATUS)) begin
                  rdata_d = status_vec;
               end else if (rd_idx == IDX_W'(REG_TIMER)) begin
                  rdata_d = bench_timer;
               end else if (!rd_in_banks) begin
                  rresp_d = RESP_SLVERR;
               end else begin
                  for (int ch = 0; ch < N_CH; ch++) begin
                     if (rd_idx[IDX_W-1:3] == (IDX_W-3)'(ch + 1)) begin
                        if (rd_off == OFF_DONE)          rdata_d = {32'h0, bench_done[ch]};
                        else if (rd_off != OFF_DOORBELL) rdata_d = bank_q[ch][rd_off - 3'd1];
                     end
                  end
               end
            end
         end
         RD_RESP: begin
            if (axi_ctrl_rready) rd_state_d = RD_IDLE;
         end
         default: rd_state_d = RD_IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         wr_state_q    <= WR_IDLE;
         rd_state_q    <= RD_IDLE;
         bresp_q       <= RESP_OKAY;
         rresp_q       <= RESP_OKAY;
         rdata_q       <= '0;
         bench_reset_q <= 1'b0;
         n_reps_q      <= '0;
         ovf_q         <= '0;
         for (int ch = 0; ch < N_CH; ch++) begin
            for (int r = 0; r < 6; r++) bank_q[ch][r] <= '0;
         end
      end else begin
         wr_state_q    <= wr_state_d;
         rd_state_q    <= rd_state_d;
         bresp_q       <= bresp_d;
         rresp_q       <= rresp_d;
         rdata_q       <= rdata_d;
         bench_reset_q <= bench_reset_d;
         n_reps_q      <= n_reps_d;
         ovf_q         <= ovf_d;
         bank_q        <= bank_d;
      end
   end

   // The bench reset pulse doubles as the queue flush.
   // req_valid therefore drops in the cycle after the pulse.
   for (genvar g = 0; g < N_CH; g++) begin : g_queue
      perf_fpga_mc_axi_ctrl_parser_req_queue #(.DEPTH(QDEPTH)) u_queue (
         .aclk    (aclk),
         .aresetn (aresetn),
         .flush   (bench_reset_q),
         .push    (q_push[g]),
         .din     (q_din[g]),
         .pop     (q_pop[g]),
         .dout    (req_desc[g]),
         .full    (q_full[g]),
         .empty   (q_empty[g]),
         .count   (q_count[g])
      );
   end

   assign axi_ctrl_awready = (wr_state_q == WR_ACK);
   assign axi_ctrl_wready  = (wr_state_q == WR_ACK);
   assign axi_ctrl_bvalid  = (wr_state_q == WR_RESP);
   assign axi_ctrl_bresp   = bresp_q;
   assign axi_ctrl_arready = (rd_state_q == RD_ACK);
   assign axi_ctrl_rvalid  = (rd_state_q == RD_RESP);
   assign axi_ctrl_rdata   = rdata_q;
   assign axi_ctrl_rresp   = rresp_q;
   assign bench_reset      = bench_reset_q;
   assign bench_n_reps     = n_reps_q;

   logic unused_bits;
   assign unused_bits = ^{axi_ctrl_awaddr[2:0], axi_ctrl_araddr[2:0], q_count};

endmodule

// File: tb/tb_perf_fpga_mc_axi_ctrl_parser.sv
// tb_perf_fpga_mc_axi_ctrl_parser
//   Directed bench for the multi-channel control parser.
//   It uses N_CH=2 and QDEPTH=4.
module tb_perf_fpga_mc_axi_ctrl_parser;
   import perf_fpga_mc_axi_ctrl_parser_pkg::*;

   localparam logic [63:0] TIMER_VAL = 64'h0123_4567_89AB_CDEF;

   logic              aclk = 1'b0;
   logic              aresetn;
   logic [15:0]       awaddr, araddr;
   logic              awvalid, awready, wvalid, wready, bvalid, bready;
   logic [63:0]       wdata, rdata;
   logic [7:0]        wstrb;
   logic [1:0]        bresp, rresp;
   logic              arvalid, arready, rvalid, rready;
   logic              bench_reset;
   logic [31:0]       bench_n_reps;
   logic [1:0][31:0]  bench_done;
   logic [63:0]       bench_timer;
   logic [1:0]        req_valid, req_ready;
   bench_req_t [1:0]  req_desc;

   int n_tests = 0;
   int n_fail  = 0;
   int rst_pulses = 0;

   always #5 aclk = ~aclk;

   perf_fpga_mc_axi_ctrl_parser #(.N_CH(2), .QDEPTH(4)) dut (
      .aclk             (aclk),
      .aresetn          (aresetn),
      .axi_ctrl_awaddr  (awaddr),
      .axi_ctrl_awvalid (awvalid),
      .axi_ctrl_awready (awready),
      .axi_ctrl_wdata   (wdata),
      .axi_ctrl_wstrb   (wstrb),
      .axi_ctrl_wvalid  (wvalid),
      .axi_ctrl_wready  (wready),
      .axi_ctrl_bresp   (bresp),
      .axi_ctrl_bvalid  (bvalid),
      .axi_ctrl_bready  (bready),
      .axi_ctrl_araddr  (araddr),
      .axi_ctrl_arvalid (arvalid),
      .axi_ctrl_arready (arready),
      .axi_ctrl_rdata   (rdata),
      .axi_ctrl_rresp   (rresp),
      .axi_ctrl_rvalid  (rvalid),
      .axi_ctrl_rready  (rready),
      .bench_reset      (bench_reset),
      .bench_n_reps     (bench_n_reps),
      .bench_done       (bench_done),
      .bench_timer      (bench_timer),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_desc         (req_desc)
   );

   // Count cycles in which the bench reset pulse is high.
   always @(negedge aclk) begin
      if (bench_reset) rst_pulses++;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: observed no finish, expected finish before 300000ns");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic axi_write(input int word, input logic [63:0] data, input logic [7:0] strb,
                            output logic [1:0] resp);
      int n;
      awaddr = 16'(word * 8); wdata = data; wstrb = strb;
      awvalid = 1'b1; wvalid = 1'b1;
      n = 0;
      do begin @(negedge aclk); n++; end while (!(awready && wready) && n < 20);
      check($sformatf("aw_ready_w%0d", word), 64'(awready && wready), 64'd1);
      @(negedge aclk);
      awvalid = 1'b0; wvalid = 1'b0;
      n = 0;
      while (!bvalid && n < 20) begin @(negedge aclk); n++; end
      check($sformatf("bvalid_w%0d", word), 64'(bvalid), 64'd1);
      resp = bresp;
      bready = 1'b1;
      @(negedge aclk);
      bready = 1'b0;
   endtask

   task automatic axi_read(input int word, output logic [63:0] data, output logic [1:0] resp);
      int n;
      araddr = 16'(word * 8); arvalid = 1'b1;
      n = 0;
      do begin @(negedge aclk); n++; end while (!arready && n < 20);
      check($sformatf("ar_ready_w%0d", word), 64'(arready), 64'd1);
      @(negedge aclk);
      arvalid = 1'b0;
      n = 0;
      while (!rvalid && n < 20) begin @(negedge aclk); n++; end
      check($sformatf("rvalid_w%0d", word), 64'(rvalid), 64'd1);
      data = rdata; resp = rresp;
      rready = 1'b1;
      @(negedge aclk);
      rready = 1'b0;
   endtask

   initial begin
      logic [1:0]  resp;
      logic [63:0] rd;
      logic [63:0] exp_v;
      int          pulses_before;

      aresetn = 1'b0;
      awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
      araddr = '0; arvalid = 1'b0; rready = 1'b0;
      bench_done = '0; bench_timer = TIMER_VAL; req_ready = '0;
      repeat (3) @(negedge aclk);

      // Reset state
      check("rst_req_valid",   64'(req_valid),    64'd0);
      check("rst_bench_reset", 64'(bench_reset),  64'd0);
      check("rst_n_reps",      64'(bench_n_reps), 64'd0);
      check("rst_awready",     64'(awready),      64'd0);
      check("rst_bvalid",      64'(bvalid),       64'd0);
      check("rst_arready",     64'(arready),      64'd0);
      check("rst_rvalid",      64'(rvalid),       64'd0);
      aresetn = 1'b1;
      @(negedge aclk);

      // Read every mapped word; STATUS shows both queues empty (bits 8,9)
      for (int w = 0; w < 24; w++) begin
         if (w >= 4 && w < 8) continue;
         axi_read(w, rd, resp);
         exp_v = (w == 2) ? 64'h300 : ((w == 3) ? TIMER_VAL : 64'h0);
         check($sformatf("sweep_data_w%0d", w), rd, exp_v);
         check($sformatf("sweep_resp_w%0d", w), 64'(resp), 64'(RESP_OKAY));
      end
      axi_read(4, rd, resp);
      check("unmapped4_data", rd, 64'h0);
      check("unmapped4_resp", 64'(resp), 64'(RESP_SLVERR));
      axi_read(24, rd, resp);
      check("unmapped24_resp", 64'(resp), 64'(RESP_SLVERR));

      // Field truncation on bank0
      axi_write(13, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, resp);
      axi_read(13, rd, resp);
      check("trunc_vaddr_b", rd, 64'h0000_FFFF_FFFF_FFFF);
      axi_write(14, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, resp);
      axi_read(14, rd, resp);
      check("trunc_pid", rd, 64'h3F);

      // Program bank1 and ring its doorbell once
      axi_write(17, 64'd16, 8'hFF, resp);         check("wr_nbeats_resp", 64'(resp), 64'(RESP_OKAY));
      axi_write(18, 64'h1000, 8'hFF, resp);       check("wr_len_a_resp",  64'(resp), 64'(RESP_OKAY));
      axi_write(20, 64'hAB000, 8'hFF, resp);      check("wr_vaddr_a_resp", 64'(resp), 64'(RESP_OKAY));
      axi_write(22, 64'd3, 8'hFF, resp);          check("wr_pid_resp",    64'(resp), 64'(RESP_OKAY));
      check("pre_db_valid", 64'(req_valid), 64'd0);
      axi_write(16, 64'h1, 8'hFF, resp);
      check("db1_resp",    64'(resp), 64'(RESP_OKAY));
      check("db1_valid",   64'(req_valid), 64'b10);
      check("db1_ctrl",    64'(req_desc[1].ctrl), 64'd1);
      check("db1_nbeats",  req_desc[1].n_beats, 64'd16);
      check("db1_len_a",   64'(req_desc[1].len_A), 64'h1000);
      check("db1_len_b",   64'(req_desc[1].len_B), 64'h0);
      check("db1_vaddr_a", 64'(req_desc[1].vaddr_A), 64'hAB000);
      check("db1_vaddr_b", 64'(req_desc[1].vaddr_B), 64'h0);
      check("db1_pid",     64'(req_desc[1].pid), 64'd3);

      // Pop it with a one-cycle ready
      req_ready = 2'b10;
      @(negedge aclk);
      req_ready = 2'b00;
      check("pop1_empty", 64'(req_valid), 64'd0);

      // Doorbell with byte 0 disabled does nothing
      axi_write(8, 64'h1, 8'h02, resp);
      check("db_nostrb_resp",  64'(resp), 64'(RESP_OKAY));
      check("db_nostrb_valid", 64'(req_valid), 64'd0);

      // Five doorbells into a 4-deep queue with distinct N_BEATS/ctrl
      for (int k = 0; k < 5; k++) begin
         axi_write(17, 64'(100 + k), 8'hFF, resp);
         axi_write(16, 64'(k & 3), 8'h01, resp);
         check($sformatf("fill_resp_%0d", k), 64'(resp),
               (k < 4) ? 64'(RESP_OKAY) : 64'(RESP_SLVERR));
      end
      axi_read(2, rd, resp);
      check("status_full_ovf", rd, 64'h0202_0102);
      axi_write(2, 64'h2_0000, 8'hFF, resp);
      check("w1c_resp", 64'(resp), 64'(RESP_OKAY));
      axi_read(2, rd, resp);
      check("status_after_w1c", rd, 64'h0200_0102);

      // Drain in FIFO order
      req_ready = 2'b10;
      for (int k = 0; k < 4; k++) begin
         check($sformatf("drain_valid_%0d", k),  64'(req_valid[1]), 64'd1);
         check($sformatf("drain_ctrl_%0d", k),   64'(req_desc[1].ctrl), 64'(k & 3));
         check($sformatf("drain_nbeats_%0d", k), req_desc[1].n_beats, 64'(100 + k));
         @(negedge aclk);
      end
      check("drain_done_valid", 64'(req_valid), 64'd0);
      req_ready = 2'b00;
      axi_read(2, rd, resp);
      check("status_drained", rd, 64'h300);

      // Fill queue0 with 3 entries, then bench reset flushes it
      axi_write(1, 64'd7, 8'hFF, resp);
      for (int k = 0; k < 3; k++) axi_write(8, 64'h2, 8'h01, resp);
      check("q0_valid", 64'(req_valid), 64'b01);
      axi_read(2, rd, resp);
      check("status_q0_3", rd, 64'h0100_0200);
      pulses_before = rst_pulses;
      axi_write(0, 64'h1, 8'h01, resp);
      check("reset_resp",    64'(resp), 64'(RESP_OKAY));
      check("reset_pulses",  64'(rst_pulses - pulses_before), 64'd1);
      check("reset_low",     64'(bench_reset), 64'd0);
      check("flush_valid",   64'(req_valid), 64'd0);
      check("n_reps_kept",   64'(bench_n_reps), 64'd7);
      axi_read(1, rd, resp);
      check("n_reps_read", rd, 64'd7);

      // Partial strobes on N_REPS
      axi_write(1, 64'hFFFF_FFFF, 8'hFF, resp);
      axi_write(1, 64'h12, 8'h01, resp);
      axi_read(1, rd, resp);
      check("strb_byte0", rd, 64'hFFFF_FF12);
      axi_write(1, 64'hAAAA_AAAA_AAAA_AAAA, 8'hF0, resp);
      axi_read(1, rd, resp);
      check("strb_upper_ignored", rd, 64'hFFFF_FF12);

      // DONE readback
      bench_done[0] = 32'd42;
      bench_done[1] = 32'h1234;
      axi_read(15, rd, resp);
      check("done0", rd, 64'd42);
      axi_read(23, rd, resp);
      check("done1", rd, 64'h1234);

      // Error responses on writes
      axi_write(3, 64'h1, 8'hFF, resp);  check("wr_timer_resp", 64'(resp), 64'(RESP_SLVERR));
      axi_write(5, 64'h1, 8'hFF, resp);  check("wr_unmap5_resp", 64'(resp), 64'(RESP_SLVERR));
      axi_write(24, 64'h1, 8'hFF, resp); check("wr_unmap24_resp", 64'(resp), 64'(RESP_SLVERR));
      axi_write(15, 64'h1, 8'hFF, resp); check("wr_done_resp", 64'(resp), 64'(RESP_SLVERR));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
